// File: rtl/switch_allocator.sv
// ---------------------------------------------------------------------------
// switch_allocator
//   Separable round-robin switch allocator for the mesh router, with the
//   downstream credit counters for every output port.
//
//   Each cycle the input units present a request and a route mask. Inputs
//   are scanned round-robin from ptr. An input wins if every port in its
//   route has credit and no earlier input in this cycle's scan has claimed
//   any of those ports. The grant is combinational, so the input unit pops
//   its FIFO on the same edge. The crossbar select and valid are registered
//   so that they line up with the input unit's registered traversal data.
//
//   Optional feature macro: SA_MULTICAST_EN
//     defined   : a route mask may name several ports. The request needs all
//                 of them free and credited, and it claims all of them.
//     undefined : each route is reduced to its lowest set bit.
//
// Ports
//   clk              system clock (rising edge)
//   rst_n            asynchronous active-low reset
//   sa_request       [NUM_IN]            request per input unit
//   sa_route         [NUM_IN*DIRECTION]  route mask, input i at [i*DIRECTION +: DIRECTION]
//   sa_grant         [NUM_IN]            same-cycle grant
//   credit_return    [DIRECTION]         downstream freed one slot on port p
//   out_credit_avail [DIRECTION]         port p has at least one credit
//   xbar_sel         [DIRECTION*NUM_IN]  one-hot input select, port p at [p*NUM_IN +: NUM_IN]
//   xbar_valid       [DIRECTION]         port p carries a flit this cycle
//   credit_err       sticky: credit returned to a full counter
// ---------------------------------------------------------------------------
`ifndef DIRECTION
`define DIRECTION 5
`endif

module switch_allocator #(
    parameter int NUM_IN       = `DIRECTION,
    parameter int CREDIT_DEPTH = 4,
    parameter int CW           = $clog2(CREDIT_DEPTH + 1)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_IN-1:0]              sa_request,
    input  logic [NUM_IN*`DIRECTION-1:0]   sa_route,
    output logic [NUM_IN-1:0]              sa_grant,
    input  logic [`DIRECTION-1:0]          credit_return,
    output logic [`DIRECTION-1:0]          out_credit_avail,
    output logic [`DIRECTION*NUM_IN-1:0]   xbar_sel,
    output logic [`DIRECTION-1:0]          xbar_valid,
    output logic                           credit_err
);

    localparam int D  = `DIRECTION;
    localparam int PW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

    logic [CW-1:0]       count [D];
    logic [PW-1:0]       ptr;
    logic [PW-1:0]       ptr_nxt;
    logic [D-1:0]        avail;
    logic [D-1:0]        claimed;
    logic [D-1:0]        route;
    logic [NUM_IN-1:0]   grant;
    logic [D*NUM_IN-1:0] sel_nxt;
    logic                any_grant;
    int                  idx;

    logic [D*NUM_IN-1:0] sel_p1;
    logic [D-1:0]        vld_p1;

    // Without multicast, keep only the lowest set bit, so a multi-hot mask
    // behaves exactly like a unicast request to its lowest port.
    function automatic logic [D-1:0] eff_route(input logic [D-1:0] r);
`ifdef SA_MULTICAST_EN
        return r;
`else
        return r & (~r + D'(1));
`endif
    endfunction

    always_comb begin
        for (int p = 0; p < D; p++) begin
            avail[p] = (count[p] != '0);
        end
    end

    assign out_credit_avail = avail;

    // Allocation: a single round-robin scan. claimed accumulates the ports
    // taken by earlier winners in this cycle, so later inputs only win on
    // disjoint routes. Grants are suppressed while reset is asserted.
    always_comb begin
        claimed   = '0;
        grant     = '0;
        sel_nxt   = '0;
        ptr_nxt   = ptr;
        any_grant = 1'b0;
        route     = '0;
        idx       = 0;
        for (int k = 0; k < NUM_IN; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_IN) begin
                idx = idx - NUM_IN;
            end
            route = eff_route(sa_route[idx*D +: D]);
            if (rst_n && sa_request[idx] && (route != '0) &&
                ((route & ~avail) == '0) && ((route & claimed) == '0)) begin
                grant[idx] = 1'b1;
                claimed    = claimed | route;
                for (int p = 0; p < D; p++) begin
                    if (route[p]) begin
                        sel_nxt[p*NUM_IN + idx] = 1'b1;
                    end
                end
                // The pointer moves past the first winner in scan order.
                if (!any_grant) begin
                    ptr_nxt = (idx == NUM_IN - 1) ? '0 : PW'(idx + 1);
                end
                any_grant = 1'b1;
            end
        end
    end

    assign sa_grant = grant;

    // ---- stage p1: crossbar control, credit counters, pointer ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr        <= '0;
            credit_err <= 1'b0;
            sel_p1     <= '0;
            vld_p1     <= '0;
            for (int p = 0; p < D; p++) begin
                count[p] <= CW'(CREDIT_DEPTH);
            end
        end else begin
            ptr    <= ptr_nxt;
            sel_p1 <= sel_nxt;
            vld_p1 <= claimed;
            for (int p = 0; p < D; p++) begin
                if (claimed[p] && !credit_return[p]) begin
                    count[p] <= count[p] - CW'(1);
                end else if (!claimed[p] && credit_return[p]) begin
                    // An extra credit on a full counter is dropped and flagged.
                    if (count[p] == CW'(CREDIT_DEPTH)) begin
                        credit_err <= 1'b1;
                    end else begin
                        count[p] <= count[p] + CW'(1);
                    end
                end
            end
        end
    end

    assign xbar_sel   = sel_p1;
    assign xbar_valid = vld_p1;

endmodule

// File: tb/tb_switch_allocator.sv
// ---------------------------------------------------------------------------
// tb_switch_allocator
//   Directed testbench for switch_allocator (NUM_IN = DIRECTION = 5,
//   CREDIT_DEPTH = 4). Expected values are written out by hand per vector.
//   Build with or without SA_MULTICAST_EN; the last group adapts.
// ---------------------------------------------------------------------------
module tb_switch_allocator;

    localparam int N = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  sa_request;
    logic [N*N-1:0] sa_route;
    logic [N-1:0]  sa_grant;
    logic [N-1:0]  credit_return;
    logic [N-1:0]  out_credit_avail;
    logic [N*N-1:0] xbar_sel;
    logic [N-1:0]  xbar_valid;
    logic          credit_err;

    int n_cmp = 0;
    int n_mis = 0;

    switch_allocator #(.NUM_IN(N), .CREDIT_DEPTH(4)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .sa_request       (sa_request),
        .sa_route         (sa_route),
        .sa_grant         (sa_grant),
        .credit_return    (credit_return),
        .out_credit_avail (out_credit_avail),
        .xbar_sel         (xbar_sel),
        .xbar_valid       (xbar_valid),
        .credit_err       (credit_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_route(input int i, input logic [N-1:0] m);
        sa_route[i*N +: N] = m;
    endtask

    task automatic clear_inputs();
        sa_request    = '0;
        sa_route      = '0;
        credit_return = '0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        clear_inputs();
        tick();
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    logic [N-1:0] rr_exp [4];

    initial begin
        rr_exp[0] = 5'b00001;
        rr_exp[1] = 5'b00100;
        rr_exp[2] = 5'b10000;
        rr_exp[3] = 5'b00001;

        // ---- reset state, grant suppressed during reset ----
        rst_n = 1'b0;
        clear_inputs();
        tick();
        sa_request = 5'b00001;
        set_route(0, 5'b00010);
        #1;
        chk("rst_grant", 32'(sa_grant), 32'h0);
        chk("rst_avail", 32'(out_credit_avail), 32'h1f);
        chk("rst_xvalid", 32'(xbar_valid), 32'h0);
        chk("rst_xsel", 32'(xbar_sel), 32'h0);
        chk("rst_err", 32'(credit_err), 32'h0);
        tick();
        chk("rst_xvalid_hold", 32'(xbar_valid), 32'h0);

        // ---- simple grant ----
        apply_reset();
        sa_request = 5'b00001;
        set_route(0, 5'b00010);
        #1;
        chk("simple_grant", 32'(sa_grant), 32'h01);
        tick();
        sa_request = '0;
        #1;
        chk("simple_xvalid", 32'(xbar_valid), 32'h02);
        chk("simple_xsel", 32'(xbar_sel), 32'h20);
        chk("simple_avail", 32'(out_credit_avail), 32'h1f);
        tick();
        chk("simple_xvalid_clr", 32'(xbar_valid), 32'h0);
        // three more grants take port 1 from 3 credits to 0
        sa_request = 5'b00001;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("simple_more_grant", 32'(sa_grant), 32'h01);
            tick();
        end
        chk("simple_cnt3_avail", 32'(out_credit_avail), 32'h1d);
        clear_inputs();

        // ---- disjoint parallel grants ----
        apply_reset();
        sa_request = 5'b01010;
        set_route(1, 5'b00001);
        set_route(3, 5'b10000);
        #1;
        chk("disj_grant", 32'(sa_grant), 32'h0a);
        tick();
        clear_inputs();
        #1;
        chk("disj_xvalid", 32'(xbar_valid), 32'h11);
        chk("disj_xsel", 32'(xbar_sel), 32'h0080_0002);

        // ---- round-robin fairness, credits replenished each cycle ----
        apply_reset();
        sa_request = 5'b10101;
        set_route(0, 5'b01000);
        set_route(2, 5'b01000);
        set_route(4, 5'b01000);
        credit_return = 5'b01000;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("rr_grant", 32'(sa_grant), 32'(rr_exp[k]));
            tick();
            chk("rr_xsel", 32'(xbar_sel), 32'(rr_exp[k]) << 15);
        end
        clear_inputs();
        #1;
        chk("rr_err", 32'(credit_err), 32'h0);
        chk("rr_avail", 32'(out_credit_avail), 32'h1f);

        // ---- credit exhaustion and recovery on port 2 ----
        apply_reset();
        sa_request = 5'b00001;
        set_route(0, 5'b00100);
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("exh_grant", 32'(sa_grant), 32'h01);
            tick();
        end
        chk("exh_avail", 32'(out_credit_avail), 32'h1b);
        chk("exh_denied", 32'(sa_grant), 32'h0);
        credit_return = 5'b00100;
        #1;
        chk("exh_ret_same_cycle", 32'(sa_grant), 32'h0);
        tick();
        credit_return = '0;
        chk("exh_ret_avail", 32'(out_credit_avail), 32'h1f);
        #1;
        chk("exh_ret_next_grant", 32'(sa_grant), 32'h01);
        tick();
        chk("exh_avail_again", 32'(out_credit_avail), 32'h1b);
        clear_inputs();

        // ---- grant and return on the same port in the same cycle ----
        apply_reset();
        sa_request = 5'b00001;
        set_route(0, 5'b00010);
        tick();                          // count[1] 4 -> 3
        credit_return = 5'b00010;
        #1;
        chk("bnd_same_grant", 32'(sa_grant), 32'h01);
        tick();                          // count[1] stays 3
        credit_return = '0;
        tick();                          // 2
        tick();                          // 1
        chk("bnd_cnt1_avail", 32'(out_credit_avail), 32'h1f);
        tick();                          // 0
        chk("bnd_cnt0_avail", 32'(out_credit_avail), 32'h1d);
        chk("bnd_no_err", 32'(credit_err), 32'h0);
        clear_inputs();

        // ---- return to a full port ----
        apply_reset();
        credit_return = 5'b00010;
        tick();
        credit_return = '0;
        chk("full_err", 32'(credit_err), 32'h1);
        chk("full_avail", 32'(out_credit_avail), 32'h1f);
        sa_request = 5'b00001;
        set_route(0, 5'b00010);
        tick();
        tick();
        tick();
        chk("full_hold_cnt1", 32'(out_credit_avail), 32'h1f);
        tick();
        chk("full_hold_cnt0", 32'(out_credit_avail), 32'h1d);
        chk("full_err_sticky", 32'(credit_err), 32'h1);
        clear_inputs();
        apply_reset();
        chk("err_cleared", 32'(credit_err), 32'h0);

        // ---- multi-hot route ----
        apply_reset();
        sa_request = 5'b00110;
        set_route(1, 5'b00010);
        set_route(2, 5'b00011);
        #1;
`ifdef SA_MULTICAST_EN
        chk("mc_deny", 32'(sa_grant), 32'h02);
        tick();
        sa_request = 5'b00100;
        chk("mc_first_xvalid", 32'(xbar_valid), 32'h02);
        chk("mc_first_xsel", 32'(xbar_sel), 32'h40);
        #1;
        chk("mc_grant", 32'(sa_grant), 32'h04);
        tick();
        clear_inputs();
        chk("mc_xvalid", 32'(xbar_valid), 32'h03);
        chk("mc_xsel", 32'(xbar_sel), 32'h84);
`else
        chk("uc_grant", 32'(sa_grant), 32'h06);
        tick();
        clear_inputs();
        chk("uc_xvalid", 32'(xbar_valid), 32'h03);
        chk("uc_xsel", 32'(xbar_sel), 32'h44);
`endif
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
